// File: rtl/prio_encoder_n_if.sv
// Handshake bundle for prio_encoder_n: request side (in_*, D) and result side
// (out_*, idx, flags, error count).
interface prio_encoder_n_if #(
  parameter int unsigned N = 8
);
  localparam int unsigned W = $clog2(N);

  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] D;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] idx;
  logic         none;
  logic         multi;
  logic [15:0]  err_cnt;

  // Producer/consumer side: drives requests and takes results.
  modport master (
    output in_valid, D, out_ready,
    input  in_ready, out_valid, idx, none, multi, err_cnt
  );

  // Encoder side.
  modport slave (
    input  in_valid, D, out_ready,
    output in_ready, out_valid, idx, none, multi, err_cnt
  );
endinterface

// File: rtl/prio_encoder_n.sv
// Registered N-to-log2(N) priority encoder, fixed-priority (highest index) or
// round-robin, with zero-hot / multi-hot flags and a saturating error count.
module prio_encoder_n #(
  parameter int unsigned N  = 8,
  parameter int unsigned RR = 0
) (
  input logic             clk,
  input logic             rst,
  prio_encoder_n_if.slave bus
);
  localparam int unsigned W      = $clog2(N);
  localparam logic [W-1:0] IdxOne = W'(1);
  localparam logic [W-1:0] IdxMax = W'(N - 1);
  localparam logic [N-1:0] VecOne = N'(1);
  localparam logic [15:0]  ErrMax = 16'hFFFF;

  if (N < 2 || N > 256) begin : gen_bad_n
    $error("prio_encoder_n: N must be within 2..256");
  end
  if (RR > 1) begin : gen_bad_rr
    $error("prio_encoder_n: RR must be 0 or 1");
  end

  logic         out_valid_q, out_valid_d;
  logic [W-1:0] idx_q, idx_d;
  logic         none_q, none_d;
  logic         multi_q, multi_d;
  logic [15:0]  err_q, err_d;
  logic [W-1:0] ptr_q, ptr_d;

  logic         accept;
  logic         d_zero;
  logic         d_multi;
  logic [W-1:0] fix_idx;
  logic [W-1:0] rr_idx;
  logic [W-1:0] sel_idx;
  logic [N-1:0] rr_mask;
  logic [N-1:0] rr_pick;

  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  assign d_zero  = (bus.D == '0);
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign d_multi = |(bus.D & (bus.D - VecOne));

  // Fixed priority: the last (highest) set bit seen wins.
  always_comb begin
    fix_idx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (bus.D[i]) fix_idx = W'(i);
    end
  end

  // Round-robin: lowest set bit at or above ptr, else lowest set bit overall
  // (which then necessarily lies below ptr, i.e. the wrapped part of the scan).
  always_comb begin
    rr_mask = '0;
    for (int unsigned i = 0; i < N; i++) begin
      rr_mask[i] = (W'(i) >= ptr_q);
    end
  end

  assign rr_pick = (|(bus.D & rr_mask)) ? (bus.D & rr_mask) : bus.D;

  always_comb begin
    rr_idx = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (rr_pick[i]) rr_idx = W'(i);
    end
  end

  assign sel_idx = (RR != 0) ? rr_idx : fix_idx;

  always_comb begin
    out_valid_d = out_valid_q;
    idx_d       = idx_q;
    none_d      = none_q;
    multi_d     = multi_q;
    err_d       = err_q;
    ptr_d       = ptr_q;
    if (accept) begin
      out_valid_d = 1'b1;
      idx_d       = sel_idx;
      none_d      = d_zero;
      multi_d     = d_multi;
      if ((d_zero || d_multi) && (err_q != ErrMax)) begin
        err_d = err_q + 16'd1;
      end
      if ((RR != 0) && !d_zero) begin
        ptr_d = (sel_idx == IdxMax) ? '0 : sel_idx + IdxOne;
      end
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      idx_q       <= '0;
      none_q      <= 1'b0;
      multi_q     <= 1'b0;
      err_q       <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      idx_q       <= idx_d;
      none_q      <= none_d;
      multi_q     <= multi_d;
      err_q       <= err_d;
      ptr_q       <= ptr_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.idx       = idx_q;
  assign bus.none      = none_q;
  assign bus.multi     = multi_q;
  assign bus.err_cnt   = err_q;

endmodule

// File: tb/tb_prio_encoder_n.sv
// Bench for prio_encoder_n: three instances (N=8 fixed, N=8 round-robin,
// N=5 round-robin) checked every cycle against a behavioural model.
module tb_prio_encoder_n;
  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       out_ready;
  logic [7:0] d8;
  logic [4:0] d5;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  prio_encoder_n_if #(.N(8)) bus_a ();
  prio_encoder_n_if #(.N(8)) bus_b ();
  prio_encoder_n_if #(.N(5)) bus_c ();

  assign bus_a.in_valid  = in_valid;
  assign bus_b.in_valid  = in_valid;
  assign bus_c.in_valid  = in_valid;
  assign bus_a.out_ready = out_ready;
  assign bus_b.out_ready = out_ready;
  assign bus_c.out_ready = out_ready;
  assign bus_a.D         = d8;
  assign bus_b.D         = d8;
  assign bus_c.D         = d5;

  prio_encoder_n #(.N(8), .RR(0)) u_fix8 (.clk(clk), .rst(rst), .bus(bus_a));
  prio_encoder_n #(.N(8), .RR(1)) u_rr8  (.clk(clk), .rst(rst), .bus(bus_b));
  prio_encoder_n #(.N(5), .RR(1)) u_rr5  (.clk(clk), .rst(rst), .bus(bus_c));

  logic        got_v[3];
  logic        got_rdy[3];
  logic [2:0]  got_idx[3];
  logic        got_none[3];
  logic        got_multi[3];
  logic [15:0] got_err[3];

  assign got_v[0] = bus_a.out_valid;   assign got_v[1] = bus_b.out_valid;
  assign got_v[2] = bus_c.out_valid;
  assign got_rdy[0] = bus_a.in_ready;  assign got_rdy[1] = bus_b.in_ready;
  assign got_rdy[2] = bus_c.in_ready;
  assign got_idx[0] = bus_a.idx;       assign got_idx[1] = bus_b.idx;
  assign got_idx[2] = bus_c.idx;
  assign got_none[0] = bus_a.none;     assign got_none[1] = bus_b.none;
  assign got_none[2] = bus_c.none;
  assign got_multi[0] = bus_a.multi;   assign got_multi[1] = bus_b.multi;
  assign got_multi[2] = bus_c.multi;
  assign got_err[0] = bus_a.err_cnt;   assign got_err[1] = bus_b.err_cnt;
  assign got_err[2] = bus_c.err_cnt;

  task automatic check(input string name, input int inst, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s[dut%0d] got=%0h expected=%0h at t=%0t", name, inst, got, exp, $time);
    end
  endtask

  // Reference selection straight from the rules: scan positions in order.
  function automatic int unsigned ref_sel(input logic [7:0] d, input int unsigned n,
                                          input bit rr, input int unsigned ptr);
    if (d == 8'h00) return 0;
    if (!rr) begin
      for (int k = int'(n) - 1; k >= 0; k--) if (d[k]) return k;
    end else begin
      for (int unsigned k = 0; k < n; k++) if (d[(ptr + k) % n]) return (ptr + k) % n;
    end
    return 0;
  endfunction

  logic        mv[3];
  logic [2:0]  midx[3];
  logic        mnone[3];
  logic        mmulti[3];
  int unsigned merr[3];
  int unsigned mptr[3];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        mv[i] <= 1'b0; midx[i] <= '0; mnone[i] <= 1'b0; mmulti[i] <= 1'b0;
        merr[i] <= 0;  mptr[i] <= 0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        automatic logic [7:0]  d  = (i == 2) ? {3'b000, d5} : d8;
        automatic int unsigned n  = (i == 2) ? 5 : 8;
        automatic bit          rr = (i != 0);
        automatic int unsigned s  = ref_sel(d, n, rr, mptr[i]);
        automatic int unsigned pc = $countones(d);
        if (in_valid && (!mv[i] || out_ready)) begin
          mv[i]     <= 1'b1;
          midx[i]   <= 3'(s);
          mnone[i]  <= (pc == 0);
          mmulti[i] <= (pc >= 2);
          if ((pc == 0 || pc >= 2) && merr[i] < 65535) merr[i] <= merr[i] + 1;
          if (rr && pc != 0) mptr[i] <= (s + 1) % n;
        end else if (mv[i] && out_ready) begin
          mv[i] <= 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        check("out_valid", i, 32'(got_v[i]), 32'(mv[i]));
        check("in_ready", i, 32'(got_rdy[i]), 32'(!mv[i] || out_ready));
        check("err_cnt", i, 32'(got_err[i]), merr[i]);
        if (mv[i]) begin
          check("idx", i, 32'(got_idx[i]), 32'(midx[i]));
          check("none", i, 32'(got_none[i]), 32'(mnone[i]));
          check("multi", i, 32'(got_multi[i]), 32'(mmulti[i]));
        end
      end
    end
  end

  // Present inputs just after an edge, then let the next edge take them.
  task automatic cyc(input logic v, input logic [7:0] a, input logic [4:0] b, input logic r);
    in_valid = v; d8 = a; d5 = b; out_ready = r;
    @(posedge clk);
    #2;
  endtask

  int exp_b[4] = '{0, 2, 7, 0};
  int exp_c[4] = '{0, 4, 0, 4};

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; d8 = '0; d5 = '0;
    #1;
    check("rst_in_ready", 0, 32'(bus_a.in_ready), 1);
    check("rst_out_valid", 0, 32'(bus_a.out_valid), 0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    check("rst_idx", 0, 32'(bus_a.idx), 0);
    check("rst_none", 0, 32'(bus_a.none), 0);
    check("rst_multi", 0, 32'(bus_a.multi), 0);
    check("rst_err", 0, 32'(bus_a.err_cnt), 0);

    for (int j = 0; j < 8; j++) begin
      cyc(1'b1, 8'(1 << j), 5'(1 << (j % 5)), 1'b1);
      check("sweep_idx", 0, 32'(bus_a.idx), j);
      check("sweep_idx", 1, 32'(bus_b.idx), j);
      check("sweep_idx", 2, 32'(bus_c.idx), j % 5);
      check("sweep_flags", 0, {30'b0, bus_a.none, bus_a.multi}, 0);
      check("sweep_err", 0, 32'(bus_a.err_cnt), 0);
    end

    cyc(1'b1, 8'b0100_1010, 5'b00010, 1'b1);
    check("fix_idx", 0, 32'(bus_a.idx), 6);
    check("fix_multi", 0, 32'(bus_a.multi), 1);
    check("fix_err", 0, 32'(bus_a.err_cnt), 1);
    cyc(1'b1, 8'h00, 5'h00, 1'b1);
    check("zero_idx", 0, 32'(bus_a.idx), 0);
    check("zero_none", 0, 32'(bus_a.none), 1);
    check("zero_err", 0, 32'(bus_a.err_cnt), 2);

    // Asynchronous reset while a result is pending.
    rst = 1'b1;
    #1;
    check("arst_out_valid", 0, 32'(bus_a.out_valid), 0);
    check("arst_out_valid", 1, 32'(bus_b.out_valid), 0);
    check("arst_none", 0, 32'(bus_a.none), 0);
    check("arst_err", 0, 32'(bus_a.err_cnt), 0);
    check("arst_in_ready", 2, 32'(bus_c.in_ready), 1);
    @(posedge clk);
    #2;
    rst = 1'b0;

    for (int k = 0; k < 4; k++) begin
      cyc(1'b1, 8'b1000_0101, 5'b10001, 1'b1);
      check("rr_idx", 1, 32'(bus_b.idx), exp_b[k]);
      check("rr_idx", 2, 32'(bus_c.idx), exp_c[k]);
    end

    cyc(1'b1, 8'h10, 5'h04, 1'b1);
    check("bp_idx", 0, 32'(bus_a.idx), 4);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, 8'h01, 5'h01, 1'b0);
      check("bp_in_ready", 0, 32'(bus_a.in_ready), 0);
      check("bp_hold_idx", 0, 32'(bus_a.idx), 4);
      check("bp_hold_valid", 0, 32'(bus_a.out_valid), 1);
    end
    cyc(1'b1, 8'h01, 5'h01, 1'b1);
    check("bp_release_idx", 0, 32'(bus_a.idx), 0);
    check("bp_release_valid", 0, 32'(bus_a.out_valid), 1);

    for (int k = 0; k < 1500; k++) begin
      automatic int unsigned m8 = $urandom_range(0, 3);
      automatic int unsigned m5 = $urandom_range(0, 3);
      automatic logic [7:0]  a  = (m8 == 0) ? 8'h00 : (m8 == 1) ? 8'(1 << $urandom_range(0, 7))
                                                                : 8'($urandom);
      automatic logic [4:0]  b  = (m5 == 0) ? 5'h00 : (m5 == 1) ? 5'(1 << $urandom_range(0, 4))
                                                                : 5'($urandom);
      cyc($urandom_range(0, 3) != 0, a, b, $urandom_range(0, 3) != 0);
    end

    for (int k = 0; k < 65537; k++) cyc(1'b1, 8'hFF, 5'h1F, 1'b1);
    check("sat_err", 0, 32'(bus_a.err_cnt), 32'hFFFF);
    check("sat_err", 1, 32'(bus_b.err_cnt), 32'hFFFF);
    check("sat_err", 2, 32'(bus_c.err_cnt), 32'hFFFF);

    in_valid = 1'b0;
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
